// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives a handshaked data-memory port, stalls the
// pipeline until the access completes and flags misaligned, illegal or timed-out accesses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] DRData,
  input  logic        DAck,
  output logic        DReq,
  output logic        DWe,
  output logic [31:0] DAddr,
  output logic [31:0] DWData,
  output logic [3:0]  DBe,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic        dreq_r, dreq_nxt_s;
  logic        dwe_r, dwe_nxt_s;
  logic [3:0]  dbe_r, dbe_nxt_s;
  logic [31:0] dwdata_r, dwdata_nxt_s;
  logic [31:0] rdata_r, rdata_nxt_s;
  logic        fault_r, fault_nxt_s;
  logic        access_s, illegal_s, timeout_s;

  function automatic logic [3:0] byte_enable(input logic byte_acc, input logic [1:0] ofs);
    logic [3:0] be;
    if (byte_acc) begin
      be = 4'b0001 << ofs;
    end else begin
      be = 4'hF;
    end
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic byte_acc, input logic [31:0] wd);
    logic [31:0] sd;
    if (byte_acc) begin
      sd = {4{wd[7:0]}};
    end else begin
      sd = wd;
    end
    return sd;
  endfunction

  // Byte loads pick the addressed lane and zero-extend it.
  function automatic logic [31:0] load_data(input logic byte_acc, input logic [1:0] ofs,
                                            input logic [31:0] rd);
    logic [31:0] ld;
    if (byte_acc) begin
      case (ofs)
        2'd0:    ld = {24'h0, rd[7:0]};
        2'd1:    ld = {24'h0, rd[15:8]};
        2'd2:    ld = {24'h0, rd[23:16]};
        2'd3:    ld = {24'h0, rd[31:24]};
        default: ld = 32'h0;
      endcase
    end else begin
      ld = rd;
    end
    return ld;
  endfunction

  assign access_s  = MemtoRegM | MemWriteM;
  assign illegal_s = (MemtoRegM & MemWriteM) | (~ByteM & (ALUOutM[1:0] != 2'b00));
  assign timeout_s = (cnt_r == TIMEOUT_LAST);

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      dreq_r   <= 1'b0;
      dwe_r    <= 1'b0;
      dbe_r    <= 4'h0;
      dwdata_r <= 32'h0;
      rdata_r  <= 32'h0;
      fault_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      dreq_r   <= dreq_nxt_s;
      dwe_r    <= dwe_nxt_s;
      dbe_r    <= dbe_nxt_s;
      dwdata_r <= dwdata_nxt_s;
      rdata_r  <= rdata_nxt_s;
      fault_r  <= fault_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          if (illegal_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (DAck || timeout_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered memory-port and result outputs.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    dreq_nxt_s   = dreq_r;
    dwe_nxt_s    = dwe_r;
    dbe_nxt_s    = dbe_r;
    dwdata_nxt_s = dwdata_r;
    rdata_nxt_s  = rdata_r;
    fault_nxt_s  = fault_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = 8'd0;
        if (access_s && !illegal_s) begin
          dreq_nxt_s   = 1'b1;
          dwe_nxt_s    = MemWriteM;
          dbe_nxt_s    = byte_enable(ByteM, ALUOutM[1:0]);
          dwdata_nxt_s = store_data(ByteM, WriteDataM);
          fault_nxt_s  = 1'b0;
        end else if (access_s) begin
          dreq_nxt_s   = 1'b0;
          dwe_nxt_s    = 1'b0;
          dbe_nxt_s    = 4'h0;
          dwdata_nxt_s = 32'h0;
          rdata_nxt_s  = 32'h0;
          fault_nxt_s  = 1'b1;
        end else begin
          dreq_nxt_s   = 1'b0;
          dwe_nxt_s    = 1'b0;
          dbe_nxt_s    = 4'h0;
          dwdata_nxt_s = 32'h0;
          fault_nxt_s  = 1'b0;
        end
      end
      WAIT: begin
        if (DAck) begin
          dreq_nxt_s   = 1'b0;
          dwe_nxt_s    = 1'b0;
          dbe_nxt_s    = 4'h0;
          dwdata_nxt_s = 32'h0;
          if (MemtoRegM) begin
            rdata_nxt_s = load_data(ByteM, ALUOutM[1:0], DRData);
          end else begin
            rdata_nxt_s = rdata_r;
          end
        end else if (timeout_s) begin
          dreq_nxt_s   = 1'b0;
          dwe_nxt_s    = 1'b0;
          dbe_nxt_s    = 4'h0;
          dwdata_nxt_s = 32'h0;
          rdata_nxt_s  = 32'h0;
          fault_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      DONE: begin
        cnt_nxt_s    = 8'd0;
        dreq_nxt_s   = 1'b0;
        dwe_nxt_s    = 1'b0;
        dbe_nxt_s    = 4'h0;
        dwdata_nxt_s = 32'h0;
        fault_nxt_s  = 1'b0;
      end
      default: begin
        cnt_nxt_s    = 8'd0;
        dreq_nxt_s   = 1'b0;
        dwe_nxt_s    = 1'b0;
        dbe_nxt_s    = 4'h0;
        dwdata_nxt_s = 32'h0;
        rdata_nxt_s  = 32'h0;
        fault_nxt_s  = 1'b0;
      end
    endcase
  end

  // The address is only driven while a request is outstanding; upstream holds ALUOutM stable.
  assign DAddr     = dreq_r ? {ALUOutM[31:2], 2'b00} : 32'h0;
  assign DReq      = dreq_r;
  assign DWe       = dwe_r;
  assign DBe       = dbe_r;
  assign DWData    = dwdata_r;
  assign ReadDataM = rdata_r;
  assign FaultM    = fault_r;
  assign StallM    = ~reset & access_s & (state_r != DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, faults, timeout,
// back-to-back accesses and reset behaviour.
module tb_mem_access_unit;

  logic        clk, reset;
  logic        MemtoRegM, MemWriteM, ByteM, DAck;
  logic [31:0] ALUOutM, WriteDataM, DRData;
  logic        DReq, DWe, StallM, FaultM;
  logic [31:0] DAddr, DWData, ReadDataM;
  logic [3:0]  DBe;

  int          vectors = 0;
  int          miscompares = 0;
  int          stalls, dreqs;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_be;
  logic        w_we;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ByteM(ByteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .DRData(DRData),
    .DAck(DAck), .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .DBe(DBe), .ReadDataM(ReadDataM), .StallM(StallM), .FaultM(FaultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one access, answers DAck after ack_after WAIT cycles (-1: never),
  // and returns at the first unstalled cycle with the observed counts.
  task automatic run_access(input logic mtr, input logic mw, input logic byt,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ack_after,
                            output int n_stall, output int n_dreq,
                            output logic [31:0] o_addr, output logic [31:0] o_data,
                            output logic [3:0] o_be, output logic o_we);
    n_stall = 0; n_dreq = 0; o_addr = 32'h0; o_data = 32'h0; o_be = 4'h0; o_we = 1'b0;
    @(negedge clk);
    MemtoRegM = mtr; MemWriteM = mw; ByteM = byt; ALUOutM = addr;
    WriteDataM = wdata; DRData = rdata; DAck = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (StallM !== 1'b1) break;
      n_stall++;
      if (DReq === 1'b1) begin
        if (n_dreq == 0) begin
          o_addr = DAddr; o_data = DWData; o_be = DBe; o_we = DWe;
        end
        n_dreq++;
      end
      @(negedge clk);
      DAck = (ack_after >= 0 && n_dreq == ack_after) ? 1'b1 : 1'b0;
      #1;
    end
  endtask

  task automatic finish_access();
    @(negedge clk);
    MemtoRegM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0; ALUOutM = 32'h0;
    WriteDataM = 32'h0; DRData = 32'h0; DAck = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0;
    ALUOutM = 32'h100; WriteDataM = 32'h0; DRData = 32'h0; DAck = 1'b0;
    @(negedge clk); #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL reset stall: got %b expected 0", StallM); end
    vectors++; if ({DReq, DWe, FaultM} !== 3'b000) begin miscompares++; $display("FAIL reset ctrl: got %b expected 000", {DReq, DWe, FaultM}); end
    vectors++; if ({DBe, DWData, ReadDataM} !== 68'h0) begin miscompares++; $display("FAIL reset data: got %h/%h/%h expected 0", DBe, DWData, ReadDataM); end
    @(negedge clk);
    reset = 1'b0; MemtoRegM = 1'b0; ALUOutM = 32'h0; DRData = 32'hFFFFFFFF; DAck = 1'b1;
    #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL idle stall: got %b expected 0", StallM); end
    @(negedge clk);
    DAck = 1'b0;
    #1;
    vectors++; if ({DReq, DWe, FaultM, DBe, DAddr, DWData, ReadDataM} !== 103'h0) begin
      miscompares++; $display("FAIL idle outputs with stray DAck: req=%b rdata=%h expected all 0", DReq, ReadDataM); end
  endtask

  task automatic test_word_load();
    run_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (stalls !== 2) begin miscompares++; $display("FAIL word_load stalls: got %0d expected 2", stalls); end
    vectors++; if (dreqs !== 1) begin miscompares++; $display("FAIL word_load dreq cycles: got %0d expected 1", dreqs); end
    vectors++; if ({w_addr, w_be, w_we} !== {32'h100, 4'hF, 1'b0}) begin miscompares++; $display("FAIL word_load port: got %h/%h/%b expected 100/f/0", w_addr, w_be, w_we); end
    vectors++; if (ReadDataM !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_load rdata: got %h expected deadbeef", ReadDataM); end
    vectors++; if ({DReq, FaultM} !== 2'b00) begin miscompares++; $display("FAIL word_load done req/fault: got %b expected 00", {DReq, FaultM}); end
    finish_access();
  endtask

  task automatic test_byte_store();
    run_access(1'b0, 1'b1, 1'b1, 32'h203, 32'h12345678, 32'h0, 0, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (stalls !== 2) begin miscompares++; $display("FAIL byte_store stalls: got %0d expected 2", stalls); end
    vectors++; if (w_addr !== 32'h200) begin miscompares++; $display("FAIL byte_store addr: got %h expected 200", w_addr); end
    vectors++; if (w_be !== 4'b1000) begin miscompares++; $display("FAIL byte_store be: got %b expected 1000", w_be); end
    vectors++; if (w_data !== 32'h78787878) begin miscompares++; $display("FAIL byte_store wdata: got %h expected 78787878", w_data); end
    vectors++; if (w_we !== 1'b1) begin miscompares++; $display("FAIL byte_store we: got %b expected 1", w_we); end
    vectors++; if (ReadDataM !== 32'hDEADBEEF) begin miscompares++; $display("FAIL byte_store rdata kept: got %h expected deadbeef", ReadDataM); end
    vectors++; if ({DReq, DWe, DBe} !== 6'h0) begin miscompares++; $display("FAIL byte_store done port: got %b expected 0", {DReq, DWe, DBe}); end
    finish_access();
  endtask

  task automatic test_byte_load();
    run_access(1'b1, 1'b0, 1'b1, 32'h41, 32'h0, 32'hAABBCCDD, 3, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (stalls !== 5) begin miscompares++; $display("FAIL byte_load stalls: got %0d expected 5", stalls); end
    vectors++; if (dreqs !== 4) begin miscompares++; $display("FAIL byte_load dreq cycles: got %0d expected 4", dreqs); end
    vectors++; if ({w_addr, w_be} !== {32'h40, 4'b0010}) begin miscompares++; $display("FAIL byte_load port: got %h/%b expected 40/0010", w_addr, w_be); end
    vectors++; if (ReadDataM !== 32'h000000CC) begin miscompares++; $display("FAIL byte_load rdata: got %h expected 000000cc", ReadDataM); end
    finish_access();
    run_access(1'b1, 1'b0, 1'b1, 32'h7, 32'h0, 32'h80112233, 0, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (ReadDataM !== 32'h00000080) begin miscompares++; $display("FAIL byte_load lane3 zext: got %h expected 00000080", ReadDataM); end
    vectors++; if (w_be !== 4'b1000) begin miscompares++; $display("FAIL byte_load lane3 be: got %b expected 1000", w_be); end
    finish_access();
  endtask

  task automatic test_word_store();
    run_access(1'b0, 1'b1, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 1, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (stalls !== 3) begin miscompares++; $display("FAIL word_store stalls: got %0d expected 3", stalls); end
    vectors++; if ({w_addr, w_data, w_be, w_we} !== {32'h104, 32'hCAFEF00D, 4'hF, 1'b1}) begin
      miscompares++; $display("FAIL word_store port: got %h/%h/%h/%b expected 104/cafef00d/f/1", w_addr, w_data, w_be, w_we); end
    vectors++; if (ReadDataM !== 32'h00000080) begin miscompares++; $display("FAIL word_store rdata kept: got %h expected 00000080", ReadDataM); end
    finish_access();
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 32'h12345678, 0, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (stalls !== 1) begin miscompares++; $display("FAIL misaligned stalls: got %0d expected 1", stalls); end
    vectors++; if (dreqs !== 0) begin miscompares++; $display("FAIL misaligned dreq cycles: got %0d expected 0", dreqs); end
    vectors++; if ({FaultM, ReadDataM} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL misaligned fault/rdata: got %b/%h expected 1/0", FaultM, ReadDataM); end
    finish_access();
    vectors++; if ({FaultM, DReq, ReadDataM} !== 34'h0) begin miscompares++; $display("FAIL misaligned after: got %b/%b/%h expected 0/0/0", FaultM, DReq, ReadDataM); end
  endtask

  task automatic test_illegal_both();
    run_access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h11223344, 0, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (ReadDataM !== 32'h11223344) begin miscompares++; $display("FAIL illegal_both setup: got %h expected 11223344", ReadDataM); end
    finish_access();
    run_access(1'b1, 1'b1, 1'b0, 32'h300, 32'h55, 32'h0, -1, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if ({stalls, dreqs} !== {32'd1, 32'd0}) begin miscompares++; $display("FAIL illegal_both stalls/dreqs: got %0d/%0d expected 1/0", stalls, dreqs); end
    vectors++; if ({FaultM, ReadDataM, DWe} !== {1'b1, 32'h0, 1'b0}) begin miscompares++; $display("FAIL illegal_both fault: got %b/%h/%b expected 1/0/0", FaultM, ReadDataM, DWe); end
    finish_access();
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'hFFFFFFFF, -1, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (dreqs !== 16) begin miscompares++; $display("FAIL timeout dreq cycles: got %0d expected 16", dreqs); end
    vectors++; if (stalls !== 17) begin miscompares++; $display("FAIL timeout stalls: got %0d expected 17", stalls); end
    vectors++; if ({FaultM, DReq, ReadDataM} !== {1'b1, 1'b0, 32'h0}) begin miscompares++; $display("FAIL timeout done: got %b/%b/%h expected 1/0/0", FaultM, DReq, ReadDataM); end
    finish_access();
    vectors++; if ({FaultM, DReq, StallM} !== 3'b000) begin miscompares++; $display("FAIL timeout after: got %b expected 000", {FaultM, DReq, StallM}); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'hA5A5A5A5, 0, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if ({ReadDataM, DReq} !== {32'hA5A5A5A5, 1'b0}) begin miscompares++; $display("FAIL b2b first: got %h/%b expected a5a5a5a5/0", ReadDataM, DReq); end
    run_access(1'b1, 1'b0, 1'b1, 32'h502, 32'h0, 32'h00990000, 0, stalls, dreqs, w_addr, w_data, w_be, w_we);
    vectors++; if (stalls !== 2) begin miscompares++; $display("FAIL b2b second stalls: got %0d expected 2", stalls); end
    vectors++; if (ReadDataM !== 32'h00000099) begin miscompares++; $display("FAIL b2b second rdata: got %h expected 00000099", ReadDataM); end
    finish_access();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    MemtoRegM = 1'b1; ByteM = 1'b0; ALUOutM = 32'h100; DRData = 32'h55AA55AA; DAck = 1'b0;
    @(negedge clk); #1;
    vectors++; if ({DReq, StallM} !== 2'b11) begin miscompares++; $display("FAIL rst_wait first wait: got %b expected 11", {DReq, StallM}); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL rst_wait stall in reset: got %b expected 0", StallM); end
    @(negedge clk);
    reset = 1'b0; MemtoRegM = 1'b0; ALUOutM = 32'h0; DAck = 1'b1;
    #1;
    vectors++; if ({DReq, StallM, ReadDataM} !== 34'h0) begin miscompares++; $display("FAIL rst_wait after reset: got %b/%b/%h expected 0/0/0", DReq, StallM, ReadDataM); end
    @(negedge clk);
    DAck = 1'b0;
    #1;
    vectors++; if ({DReq, FaultM, ReadDataM} !== 34'h0) begin miscompares++; $display("FAIL rst_wait late DAck: got %b/%b/%h expected 0/0/0", DReq, FaultM, ReadDataM); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_word_store();
    test_misaligned();
    test_illegal_both();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
